// File: rtl/pipe_adder.sv
// pipe_adder: pipelined carry-ripple adder, one SEG-bit segment per stage.
// The carry and the not-yet-added operand bits move down the pipeline with
// each result. A valid/ready handshake on both sides gives full throughput
// and backpressure. Latency is NSEG cycles, counting the accept edge.
// Optional feature: define PIPE_ADDER_OVF_EN to add the signed-overflow
// output ovf, which is aligned with sum.
// WIDTH must be a multiple of SEG.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = WIDTH / SEG;

  // Per-stage registers. The operand registers hold the unadded upper bits,
  // shifted down so that the next segment always sits at [SEG-1:0]. The sum
  // register fills from the top, one segment per stage.
  logic [NSEG-1:0]  v_q, v_d;
  logic [NSEG-1:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];

  // Values presented to the input of each stage.
  logic [WIDTH-1:0] op_a [NSEG];
  logic [WIDTH-1:0] op_b [NSEG];
  logic [WIDTH-1:0] op_s [NSEG];
  logic [NSEG-1:0]  op_c, op_v;
  logic [SEG:0]     seg_sum [NSEG];

  // Stage k loads when it is empty or when its content moves on.
  logic [NSEG-1:0]  load_en;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  // Load-enable chain, combinational from out_ready back to in_ready.
  always_comb begin
    // NOTE: every bit gets a default first, so no path can infer a latch.
    load_en          = '0;
    load_en[NSEG-1]  = !v_q[NSEG-1] || out_ready;
    for (int k = NSEG - 2; k >= 0; k--) begin
      load_en[k] = !v_q[k] || load_en[k+1];
    end
  end

  // Stage inputs: stage 0 sees the ports, stage k sees register k-1.
  always_comb begin
    op_a[0] = a;
    op_b[0] = b;
    op_s[0] = '0;
    op_c[0] = cin;
    op_v[0] = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_s[k] = s_q[k-1];
      op_c[k] = c_q[k-1];
      op_v[k] = v_q[k-1];
    end
  end

  // Per-stage segment add. This also computes the next skew/sum register values.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg_sum[k] = seg_add(op_a[k][SEG-1:0], op_b[k][SEG-1:0], op_c[k]);
      s_d[k]     = (op_s[k] >> SEG) |
                   (WIDTH'(seg_sum[k][SEG-1:0]) << (WIDTH - SEG));
      a_d[k]     = op_a[k] >> SEG;
      b_d[k]     = op_b[k] >> SEG;
      c_d[k]     = seg_sum[k][SEG];
      v_d[k]     = op_v[k];
    end
  end

  // Pipeline registers. A stalled stage holds. Data is loaded only with a
  // valid item, so a result stays put even after it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are cleared as well, so sum/cout read 0 after reset.
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (load_en[k]) begin
          // NOTE: state updates are non-blocking, so all stages shift on the same edge.
          v_q[k] <= v_d[k];
          if (v_d[k]) begin
            c_q[k] <= c_d[k];
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
          end
        end
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow from the sign bits. These reach the last stage as the
  // top bit of its segment.
  always_comb begin
    ovf_d = (op_a[NSEG-1][SEG-1] == op_b[NSEG-1][SEG-1]) &&
            (seg_sum[NSEG-1][SEG-1] != op_a[NSEG-1][SEG-1]);
  end

  // Overflow register. It moves with the last stage, so it stays aligned with sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (load_en[NSEG-1] && v_d[NSEG-1]) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = load_en[0];
  assign out_valid = v_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined carry-ripple adder. It is the successor to the fixed 4/8-bit ripple adders.
- Operands are split into SEG-bit segments. One segment is added per pipeline stage, and the carry is registered between stages.
- A valid/ready handshake on both sides gives full throughput and backpressure.
- Used wherever wide additions (32/64-bit) must meet timing inside datapath blocks.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; NSEG = WIDTH/SEG stages (NSEG >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b/cin presented.
- in_ready  output  1  stage 0 can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  a + b + cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset:
  - Single clock domain clk.
  - rst is asynchronous and active-high; it is asserted asynchronously and released synchronously by the environment.
  - On rst, every stage valid bit clears, out_valid=0, sum=0, cout=0.
  - in_ready=1 as soon as rst deasserts.
  - Stage data registers are also cleared to 0.
- Pipeline structure:
  - Stage k (k = 0..NSEG-1) holds: valid bit v[k], carry c[k], completed low sum bits, and not-yet-added upper operand bits of a and b (skew registers).
  - Stage 0 adds a[SEG-1:0] + b[SEG-1:0] + cin.
  - Stage k adds segment k of the carried operands + c[k-1].
  - The last stage drives sum, cout and out_valid = v[NSEG-1].
- Handshake:
  - Transfer into the adder occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - The last stage advances when out_ready || !v[NSEG-1].
  - Stage k < NSEG-1 advances when stage k+1 advances || !v[k+1].
  - in_ready = stage 0 advances || !v[0]. This is combinational from out_ready through the chain; it allows one transfer per cycle with out_ready held high.
  - An empty stage receiving nothing stays empty. A stage that advances without new input becomes empty (v=0).
  - Data in a stalled stage holds stable; sum/cout must not change while out_valid && !out_ready.
- Latency and throughput:
  - Latency is NSEG cycles from accept edge to out_valid, with no stalls.
  - Throughput is 1 result per cycle.
  - Capacity is NSEG results in flight.
  - Ordering is strict FIFO.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; cout is the true carry.
  - NSEG=1 degenerates to a single registered adder stage.
  - Result must equal {cout,sum} = a + b + cin for all inputs.
- Boundary conditions:
  - Simultaneous accept and drain while full: allowed, no bubble, no loss.
  - in_valid dropping with no accept: no effect.
  - rst mid-operation: all in-flight results are discarded; no spurious out_valid after release.
  - in_valid=1 during rst: ignored.
  - a/b may change freely when not accepted.

Optional Feature:
- Macro PIPE_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), with cin included in the sum.
  - ovf is computed in the last stage from skewed sign bits.
  - ovf is aligned with sum, held under stall, and reset to 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, SEG=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0 -> out_valid after exactly 4 cycles, sum=0x0000, cout=1.
- Back-to-back accepts, 8 consecutive pairs (i, 0x1000*i), cin=i[0] -> 8 consecutive results in order, one per cycle, each equal to a+b+cin; in_ready stays 1.
- Backpressure: fill with 4 operations, out_ready=0 for 6 cycles -> in_ready=0 once 4 are held, sum/cout stable; release -> all 4 drain in order, nothing lost or duplicated.
- Reset mid-flight: accept 0x1234+0x4321, assert rst at cycle 2 -> out_valid=0, sum=0 immediately; after release, no result appears within 8 cycles.
- With PIPE_ADDER_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1; 0x0001+0xFFFF -> ovf=0.
- Random: 10k constrained-random operands with random in_valid/out_ready, WIDTH in {8,32,64}, SEG in {1,4,8} -> scoreboard matches, order preserved.
